axm_job_queue: RTL and testbench
================================

// Module: axm_job_queue
// PURPOSE
//  Wishbone-slave job queue placed directly upstream of the approximate multiplier core.
//  CPU writes operand pairs into an operand FIFO; block issues them to the multiplier over
//  valid/ready, captures products into a result FIFO, and CPU reads them back. Decouples
//  bus timing from multiplier latency; lives inside user_project_wrapper on wb_clk_i.
// PARAMETERS
//  OP_W       16            operand width; product width is 2*OP_W (must be <= 16)
//  DEPTH      8             entries per FIFO (power of 2, >= 2)
//  MAX_INFL   4             max jobs issued to multiplier but not yet returned
//  BASE_ADR   32'h3000_0000 Wishbone base address; decode on wbs_adr_i[31:4]
// PORTS
//  wb_clk_i      in   1       clock
//  wb_rst_ni     in   1       asynchronous active-low reset
//  wbs_cyc_i     in   1       Wishbone cycle
//  wbs_stb_i     in   1       Wishbone strobe
//  wbs_we_i      in   1       Wishbone write enable
//  wbs_sel_i     in   4       byte selects (ignored; full-word access only)
//  wbs_adr_i     in   32      address
//  wbs_dat_i     in   32      write data
//  wbs_ack_o     out  1       acknowledge
//  wbs_dat_o     out  32      read data
//  mul_a_o       out  OP_W    operand A to multiplier
//  mul_b_o       out  OP_W    operand B to multiplier
//  mul_valid_o   out  1       operand pair valid
//  mul_ready_i   in   1       multiplier accepts pair when valid&ready
//  mul_p_i       in   2*OP_W  product from multiplier, in issue order
//  mul_p_valid_i in   1       product valid (one-cycle pulse per product)
//  irq_o         out  1       result-available interrupt (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; FIFOs empty; in-flight counter 0; sticky flags and CTRL cleared.
//  Bus: hit when cyc&stb&adr[31:4]==BASE_ADR[31:4] and ack low; ack is a 1-cycle pulse the
//   cycle after hit; wbs_dat_o valid with ack, 0 otherwise. Non-hit: no ack.
//  Register map (offset):
//   0x0 OPND  W: push {b=dat[31:16], a=dat[15:0]} (OP_W LSBs of each half). R: 0.
//   0x4 RSLT  R: pop result FIFO, return product zero-extended. W: ignored.
//   0x8 STAT  R: [3:0] op count, [7:4] result count, [11:8] in-flight, [16] op full,
//             [17] result empty, [24] sticky overflow, [25] sticky underflow.
//   0xC CTRL  W: [0] flush (self-clearing), [1] clear sticky, [2] irq enable. R: [2].
//  Counts saturate at 15 in STAT fields. Push/pop take effect on ack cycle.
//  OPND write while op FIFO full: data dropped, sticky overflow set, still acked.
//  RSLT read while result FIFO empty: returns 32'h0, sticky underflow set, still acked.
//  Issue: mul_valid_o = op FIFO non-empty & infl<MAX_INFL & (res_count+infl)<DEPTH;
//   mul_a_o/mul_b_o driven from op FIFO head; pop on valid&ready. Once valid is high,
//   a/b hold stable until the handshake completes.
//  Return: mul_p_valid_i pushes mul_p_i into result FIFO, infl decrements. Credit rule
//   guarantees no result-FIFO overflow. mul_p_valid_i with infl==0: ignored, sets overflow.
//  Simultaneous issue and return in one cycle: infl unchanged. Simultaneous bus push and
//   issue pop on op FIFO: both occur; count unchanged. Same for result push + bus pop.
//  Flush: empties both FIFOs next cycle; in-flight products still returning are discarded
//   (counted down, not stored); issue blocked until infl==0.
//  Pointers wrap modulo DEPTH; full/empty via count, not pointer equality.
// CONFIGURATION
//  AXM_JOB_IRQ_EN defined: irq_o registered = CTRL[2] & result FIFO non-empty; it deasserts
//   the cycle after the last result is popped.
//  Not defined: irq_o tied 0; CTRL[2] reads 0; no irq logic synthesized.
// TESTING
//  Write OPND 0x0003_0005, multiplier model latency 3 -> RSLT read returns exact model
//   product; STAT in-flight 1 then 0.
//  Write 9 operands, mul_ready_i held 0, DEPTH=8 -> 9th dropped, STAT[24]=1, op count 8.
//  Read RSLT when empty -> 0x0000_0000, STAT[25]=1; CTRL write 0x2 -> both sticky flags 0.
//  Push 8 operands, no result reads -> issue stops with res_count+infl==8; pop 1 -> 1 issue.
//  Hold mul_ready_i low 5 cycles with valid high -> a/b stable; raise -> single pop.
//  Flush with 2 jobs in flight -> returns discarded, STAT counts 0; irq (if EN) never set.

Source files
------------

// File: rtl/axm_job_queue.sv
// axm_job_queue: Wishbone-slave job queue in front of the approximate multiplier.
// Operand pairs written over the bus are issued to the multiplier under a credit
// scheme, and products are buffered for CPU readback.
// Optional feature macro: AXM_JOB_IRQ_EN (result-available interrupt).
module axm_job_queue #(
    parameter int unsigned OP_W     = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned MAX_INFL = 4,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic [OP_W-1:0]   mul_a_o,
    output logic [OP_W-1:0]   mul_b_o,
    output logic              mul_valid_o,
    input  logic              mul_ready_i,
    input  logic [2*OP_W-1:0] mul_p_i,
    input  logic              mul_p_valid_i,
    output logic              irq_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = $clog2(MAX_INFL + 1);
    localparam int unsigned SW = ((CW > IW) ? CW : IW) + 1;
    localparam int unsigned PW = 2 * OP_W;

    localparam logic [1:0] OFF_OPND = 2'd0;
    localparam logic [1:0] OFF_RSLT = 2'd1;
    localparam logic [1:0] OFF_STAT = 2'd2;
    localparam logic [1:0] OFF_CTRL = 2'd3;

    // bus request capture
    logic        ack_q;
    logic        req_we_q;
    logic [1:0]  req_off_q;
    logic [31:0] req_dat_q;
    logic        hit;

    // operand FIFO
    logic [PW-1:0] op_mem [DEPTH];
    logic [AW-1:0] op_wr_q, op_wr_d, op_rd_q, op_rd_d;
    logic [CW-1:0] op_cnt_q, op_cnt_d;

    // result FIFO
    logic [PW-1:0] res_mem [DEPTH];
    logic [AW-1:0] res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [CW-1:0] res_cnt_q, res_cnt_d;

    // in-flight tracking and status
    logic [IW-1:0] infl_q, infl_d;
    logic          drain_q, drain_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic wr_opnd, rd_rslt, wr_ctrl;
    logic op_full, op_empty, res_full, res_empty;
    logic op_push, op_ovf, op_pop, issue_ok;
    logic res_push, res_pop, res_unf;
    logic ret_ok, ret_spur;
    logic flush_now, sticky_clr;
    logic ctrl_irq_rd;
    logic [31:0] rd_data;
    logic [PW-1:0] op_head;

    function automatic logic [3:0] sat4(input logic [31:0] v);
        if (v > 32'd15) return 4'hF;
        return v[3:0];
    endfunction

    assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]) & ~ack_q;

    // ack one cycle after a hit; latch the request so side effects happen on the ack cycle
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q     <= 1'b0;
            req_we_q  <= 1'b0;
            req_off_q <= 2'd0;
            req_dat_q <= 32'd0;
        end else begin
            ack_q <= hit;
            if (hit) begin
                req_we_q  <= wbs_we_i;
                req_off_q <= wbs_adr_i[3:2];
                req_dat_q <= wbs_dat_i;
            end
        end
    end

    assign wr_opnd = ack_q &  req_we_q & (req_off_q == OFF_OPND);
    assign rd_rslt = ack_q & ~req_we_q & (req_off_q == OFF_RSLT);
    assign wr_ctrl = ack_q &  req_we_q & (req_off_q == OFF_CTRL);

    assign op_full   = (op_cnt_q == CW'(DEPTH));
    assign op_empty  = (op_cnt_q == '0);
    assign res_full  = (res_cnt_q == CW'(DEPTH));
    assign res_empty = (res_cnt_q == '0);

    assign flush_now  = wr_ctrl & req_dat_q[0];
    assign sticky_clr = wr_ctrl & req_dat_q[1];

    assign op_push = wr_opnd & ~op_full;
    assign op_ovf  = wr_opnd &  op_full;

    // credit rule: every issued job must have a result slot reserved
    assign issue_ok = ~op_empty & ~drain_q & (infl_q < IW'(MAX_INFL)) &
                      ((SW'(res_cnt_q) + SW'(infl_q)) < SW'(DEPTH));
    assign op_pop   = issue_ok & mul_ready_i;

    assign ret_ok   = mul_p_valid_i & (infl_q != '0);
    assign ret_spur = mul_p_valid_i & (infl_q == '0);
    assign res_push = ret_ok & ~drain_q & ~flush_now & ~res_full;
    assign res_pop  = rd_rslt & ~res_empty;
    assign res_unf  = rd_rslt &  res_empty;

    assign op_head     = op_mem[op_rd_q];
    assign mul_valid_o = issue_ok;
    assign mul_a_o     = op_head[OP_W-1:0];
    assign mul_b_o     = op_head[PW-1:OP_W];

    // next-state for FIFO pointers/counts, in-flight counter, drain and sticky flags
    always_comb begin
        op_wr_d   = op_wr_q;
        op_rd_d   = op_rd_q;
        op_cnt_d  = op_cnt_q;
        res_wr_d  = res_wr_q;
        res_rd_d  = res_rd_q;
        res_cnt_d = res_cnt_q;
        infl_d    = infl_q;
        drain_d   = drain_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;

        if (flush_now) begin
            op_wr_d   = '0;
            op_rd_d   = '0;
            op_cnt_d  = '0;
            res_wr_d  = '0;
            res_rd_d  = '0;
            res_cnt_d = '0;
        end else begin
            if (op_push) op_wr_d = op_wr_q + AW'(1);
            if (op_pop)  op_rd_d = op_rd_q + AW'(1);
            case ({op_push, op_pop})
                2'b10:   op_cnt_d = op_cnt_q + CW'(1);
                2'b01:   op_cnt_d = op_cnt_q - CW'(1);
                default: op_cnt_d = op_cnt_q;
            endcase
            if (res_push) res_wr_d = res_wr_q + AW'(1);
            if (res_pop)  res_rd_d = res_rd_q + AW'(1);
            case ({res_push, res_pop})
                2'b10:   res_cnt_d = res_cnt_q + CW'(1);
                2'b01:   res_cnt_d = res_cnt_q - CW'(1);
                default: res_cnt_d = res_cnt_q;
            endcase
        end

        case ({op_pop, ret_ok})
            2'b10:   infl_d = infl_q + IW'(1);
            2'b01:   infl_d = infl_q - IW'(1);
            default: infl_d = infl_q;
        endcase

        // products issued before a flush are counted down but never stored
        if (flush_now)
            drain_d = (infl_d != '0);
        else if (drain_q && (infl_d == '0))
            drain_d = 1'b0;

        if (sticky_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (op_ovf || ret_spur) ovf_d = 1'b1;
        if (res_unf)            unf_d = 1'b1;
    end

    // state registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            op_wr_q   <= '0;
            op_rd_q   <= '0;
            op_cnt_q  <= '0;
            res_wr_q  <= '0;
            res_rd_q  <= '0;
            res_cnt_q <= '0;
            infl_q    <= '0;
            drain_q   <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            op_wr_q   <= op_wr_d;
            op_rd_q   <= op_rd_d;
            op_cnt_q  <= op_cnt_d;
            res_wr_q  <= res_wr_d;
            res_rd_q  <= res_rd_d;
            res_cnt_q <= res_cnt_d;
            infl_q    <= infl_d;
            drain_q   <= drain_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge wb_clk_i) begin
        if (op_push)  op_mem[op_wr_q]   <= {req_dat_q[16 +: OP_W], req_dat_q[0 +: OP_W]};
        if (res_push) res_mem[res_wr_q] <= mul_p_i;
    end

`ifdef AXM_JOB_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q;

    // irq enable next-state from CTRL writes
    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_ctrl) irq_en_d = req_dat_q[2];
    end

    // irq registered from next-state so it drops right after the last pop
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_d & (res_cnt_d != '0);
        end
    end

    assign irq_o       = irq_q;
    assign ctrl_irq_rd = irq_en_q;
`else
    assign irq_o       = 1'b0;
    assign ctrl_irq_rd = 1'b0;
`endif

    // read mux evaluated on the ack cycle
    always_comb begin
        rd_data = 32'd0;
        case (req_off_q)
            OFF_RSLT: if (!res_empty) rd_data = 32'(res_mem[res_rd_q]);
            OFF_STAT: begin
                rd_data[3:0]  = sat4(32'(op_cnt_q));
                rd_data[7:4]  = sat4(32'(res_cnt_q));
                rd_data[11:8] = sat4(32'(infl_q));
                rd_data[16]   = op_full;
                rd_data[17]   = res_empty;
                rd_data[24]   = ovf_q;
                rd_data[25]   = unf_q;
            end
            OFF_CTRL: rd_data[2] = ctrl_irq_rd;
            default:  rd_data = 32'd0;
        endcase
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = (ack_q & ~req_we_q) ? rd_data : 32'd0;

    logic unused_ok;
    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0], req_dat_q};

endmodule

// File: tb/tb_axm_job_queue.sv
// Scoreboard bench for axm_job_queue: reads push expected words, a monitor
// compares on every read ack; a behavioural multiplier returns a*b after lat cycles.
module tb_axm_job_queue;

    localparam logic [31:0] A_OPND = 32'h3000_0000;
    localparam logic [31:0] A_RSLT = 32'h3000_0004;
    localparam logic [31:0] A_STAT = 32'h3000_0008;
    localparam logic [31:0] A_CTRL = 32'h3000_000C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [15:0] mul_a_o, mul_b_o;
    logic        mul_valid_o;
    logic        mul_ready;
    logic [31:0] mul_p;
    logic        mul_p_valid;
    logic        irq_o;

    int errors = 0;
    int checks = 0;
    int lat    = 3;
    int ncyc   = 0;

    logic [31:0] exp_q [$];
    string       nm_q  [$];

    typedef struct {
        logic [31:0] p;
        int          due;
    } ret_t;
    ret_t pend [$];

    axm_job_queue dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .wbs_cyc_i     (cyc),
        .wbs_stb_i     (stb),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (dat),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .mul_a_o       (mul_a_o),
        .mul_b_o       (mul_b_o),
        .mul_valid_o   (mul_valid_o),
        .mul_ready_i   (mul_ready),
        .mul_p_i       (mul_p),
        .mul_p_valid_i (mul_p_valid),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;

    // multiplier model: valid/ready are stable at negedge (ready changes just after posedge)
    always @(negedge clk) begin
        ret_t r;
        ncyc++;
        mul_p_valid = 1'b0;
        mul_p       = 32'd0;
        if (rst_n && mul_valid_o && mul_ready) begin
            r.p   = 32'(mul_a_o) * 32'(mul_b_o);
            r.due = ncyc + lat;
            pend.push_back(r);
        end
        if (pend.size() > 0 && pend[0].due <= ncyc) begin
            mul_p_valid = 1'b1;
            mul_p       = pend[0].p;
            void'(pend.pop_front());
        end
    end

    // scoreboard monitor: every read ack consumes one expected word
    always @(negedge clk) begin
        logic [31:0] e;
        string       n;
        if (rst_n && wbs_ack_o && !we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %h, no read was expected", wbs_dat_o);
            end else begin
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                if (wbs_dat_o !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", n, wbs_dat_o, e);
                end
            end
        end
    end

    function automatic logic [31:0] stat(int opc, int resc, int infl,
                                         bit opf, bit rese, bit ov, bit un);
        return {6'd0, un, ov, 6'd0, rese, opf, 4'd0, 4'(infl), 4'(resc), 4'(opc)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d);
        int n;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wbs_ack_o && n < 8);
        checks++;
        if (!wbs_ack_o) begin
            errors++;
            $display("FAIL ack_timeout: adr %h got no ack within %0d cycles", a, n);
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        wb_cycle(a, 1'b1, d);
    endtask

    task automatic wb_read(input logic [31:0] a, input logic [31:0] e, input string nm);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        wb_cycle(a, 1'b0, 32'd0);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 mul_ready = v;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF;
        adr = 32'd0; dat = 32'd0; mul_ready = 1'b1;
        wait_cyc(3);
        chk("rst_ack",   32'(wbs_ack_o),   32'd0);
        chk("rst_dat",   wbs_dat_o,        32'd0);
        chk("rst_valid", 32'(mul_valid_o), 32'd0);
        chk("rst_irq",   32'(irq_o),       32'd0);
        rst_n = 1'b1;
        wait_cyc(2);
        wb_read(A_STAT, stat(0, 0, 0, 0, 1, 0, 0), "stat_reset");

        // single job, latency 3: 5*3
        wb_write(A_OPND, 32'h0003_0005);
        wb_read(A_STAT, stat(0, 0, 1, 0, 1, 0, 0), "stat_inflight1");
        wait_cyc(8);
        wb_read(A_STAT, stat(0, 1, 0, 0, 0, 0, 0), "stat_inflight0");
        wb_read(A_RSLT, 32'h0000_000F, "rslt_5x3");
        wb_read(A_STAT, stat(0, 0, 0, 0, 1, 0, 0), "stat_after_pop");
        wb_read(A_RSLT, 32'h0, "rslt_none_yet");
        wb_write(A_CTRL, 32'h2);

        // overflow: 9 pushes with ready low, a=1..9, b=2
        set_ready(1'b0);
        for (int i = 0; i < 9; i++)
            wb_write(A_OPND, {16'd2, 16'(i + 1)});
        wb_read(A_STAT, stat(8, 0, 0, 1, 1, 1, 0), "stat_overflow");

        // operands stable while stalled, then exactly one handshake
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(mul_valid_o), 32'd1);
            chk("stall_a",     32'(mul_a_o),     32'd1);
            chk("stall_b",     32'(mul_b_o),     32'd2);
        end
        set_ready(1'b1);
        set_ready(1'b0);
        wait_cyc(8);
        wb_read(A_STAT, stat(7, 1, 0, 0, 0, 1, 0), "stat_single_pop");
        chk("next_head_a", 32'(mul_a_o), 32'd2);
        wb_read(A_RSLT, 32'h0000_0002, "rslt_1x2");

        // underflow then sticky clear
        wb_read(A_RSLT, 32'h0, "rslt_underflow");
        wb_read(A_STAT, stat(7, 0, 0, 0, 1, 1, 1), "stat_sticky_both");
        wb_write(A_CTRL, 32'h2);
        wb_read(A_STAT, stat(7, 0, 0, 0, 1, 0, 0), "stat_sticky_clr");

        // credit: fill result FIFO, further issue must stall
        wb_write(A_OPND, {16'd1, 16'd20});
        set_ready(1'b1);
        wait_cyc(40);
        wb_write(A_OPND, {16'd3, 16'd10});
        wb_write(A_OPND, {16'd3, 16'd11});
        wait_cyc(10);
        chk("credit_stall", 32'(mul_valid_o), 32'd0);
        wb_read(A_STAT, stat(2, 8, 0, 0, 0, 0, 0), "stat_credit_full");
        wb_read(A_RSLT, 32'h0000_0004, "rslt_2x2");
        wait_cyc(12);
        wb_read(A_STAT, stat(1, 8, 0, 0, 0, 0, 0), "stat_one_more_issue");
        chk("credit_stall2", 32'(mul_valid_o), 32'd0);

        // flush with two jobs in flight
        wb_write(A_CTRL, 32'h1);
        wb_read(A_STAT, stat(0, 0, 0, 0, 1, 0, 0), "stat_flush1");
        set_ready(1'b0);
        lat = 30;
        wb_write(A_OPND, 32'h0005_0005);
        wb_write(A_OPND, 32'h0006_0006);
        set_ready(1'b1);
        wait_cyc(3);
        set_ready(1'b0);
        wb_read(A_STAT, stat(0, 0, 2, 0, 1, 0, 0), "stat_two_inflight");
        wb_write(A_CTRL, 32'h5);
        set_ready(1'b1);
        wb_write(A_OPND, 32'h0007_0007);
        wb_read(A_STAT, stat(1, 0, 2, 0, 1, 0, 0), "stat_drain_blocked");
        chk("irq_after_flush", 32'(irq_o), 32'd0);
        wait_cyc(80);
`ifdef AXM_JOB_IRQ_EN
        chk("irq_result", 32'(irq_o), 32'd1);
        wb_read(A_CTRL, 32'h4, "ctrl_read");
`else
        chk("irq_result", 32'(irq_o), 32'd0);
        wb_read(A_CTRL, 32'h0, "ctrl_read");
`endif
        wb_read(A_STAT, stat(0, 1, 0, 0, 0, 0, 0), "stat_after_drain");
        wb_read(A_RSLT, 32'h0000_0031, "rslt_7x7");
        wait_cyc(2);
        chk("irq_cleared", 32'(irq_o), 32'd0);
        wb_read(A_STAT, stat(0, 0, 0, 0, 1, 0, 0), "stat_final");

        wait_cyc(2);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
